// File: rtl/sdram_p2_bridge_pkg.sv
// ----------------------------------------------------------------------------
// sdram_p2_bridge_pkg
// Shared definitions for the SDRAM port-2 bridge: bus widths, the bridge FSM
// state encoding and the layout of one queued host request.
// ----------------------------------------------------------------------------
package sdram_p2_bridge_pkg;

    localparam int P2_ADDR_W = 22;
    localparam int P2_DATA_W = 16;
    localparam int P2_DS_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } bridge_state_t;

    // One request as held in the FIFO.
    typedef struct packed {
        logic                 we;
        logic [P2_ADDR_W-1:0] addr;
        logic [P2_DS_W-1:0]   ds;
        logic [P2_DATA_W-1:0] wdata;
    } req_entry_t;

endpackage

// File: rtl/sdram_p2_bridge_if.sv
// ----------------------------------------------------------------------------
// sdram_p2_bridge_if
// Host-side request/response bus of the SDRAM port-2 bridge.
//   req_valid/req_ready : request handshake (accepted when both are 1)
//   req_we/addr/ds/wdata: request payload (word address, write byte mask)
//   rsp_valid           : one-cycle completion pulse
//   rsp_we/rsp_rdata    : kind of completed op and read data
// master = host side, slave = bridge side.
// ----------------------------------------------------------------------------
interface sdram_p2_bridge_if;
    import sdram_p2_bridge_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [P2_ADDR_W-1:0] req_addr;
    logic [P2_DS_W-1:0]   req_ds;
    logic [P2_DATA_W-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_we;
    logic [P2_DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_ds, req_wdata,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_ds, req_wdata,
        output req_ready, rsp_valid, rsp_we, rsp_rdata
    );

endinterface

// File: rtl/sdram_req_fifo.sv
// ----------------------------------------------------------------------------
// sdram_req_fifo
// Synchronous request FIFO for the port-2 bridge.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   i_push/i_data: write one entry (ignored when full, even if popping)
//   i_pop        : drop the head entry (ignored when empty)
//   o_head       : current head entry
//   o_full/o_empty/o_level : occupancy status
// ----------------------------------------------------------------------------
module sdram_req_fifo
    import sdram_p2_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  req_entry_t               i_data,
    input  logic                     i_pop,
    output req_entry_t               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

    req_entry_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;

    logic            w_full;
    logic            w_empty;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    // Fullness is judged before the pop, so a full FIFO refuses a push
    // even when the head leaves in the same cycle.
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sdram_p2_bridge.sv
// ----------------------------------------------------------------------------
// sdram_p2_bridge
// Queues host requests and replays them one at a time on port 2 of the SDRAM
// controller, returning a one-cycle response per completed access, in order.
// Ports:
//   clk, reset_n   : controller clock, synchronous active-low reset
//   i_ram_ready    : controller initialised
//   bus            : host request/response bus (slave side)
//   o_p2_cs/we/addr/ds/din, i_p2_dout, i_p2_ack : controller port 2;
//                    i_p2_ack toggles once per completed access
//   o_level        : FIFO occupancy
//   o_busy         : FIFO non-empty or an access in flight
// ----------------------------------------------------------------------------
module sdram_p2_bridge
    import sdram_p2_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_ram_ready,
    sdram_p2_bridge_if.slave         bus,
    output logic                     o_p2_cs,
    output logic                     o_p2_we,
    output logic [P2_ADDR_W-1:0]     o_p2_addr,
    output logic [P2_DS_W-1:0]       o_p2_ds,
    output logic [P2_DATA_W-1:0]     o_p2_din,
    input  logic [P2_DATA_W-1:0]     i_p2_dout,
    input  logic                     i_p2_ack,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy
);

    bridge_state_t          r_state;
    logic                   r_ack_exp;
    logic                   r_p2_cs;
    logic                   r_p2_we;
    logic [P2_ADDR_W-1:0]   r_p2_addr;
    logic [P2_DS_W-1:0]     r_p2_ds;
    logic [P2_DATA_W-1:0]   r_p2_din;
    logic                   r_rsp_valid;
    logic                   r_rsp_we;
    logic [P2_DATA_W-1:0]   r_rsp_rdata;

    req_entry_t             w_entry;
    req_entry_t             w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_level;
    logic                   w_req_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ack_seen;

    // Hold off the host while reset is asserted.
    assign w_req_ready = reset_n & ~w_full;
    assign w_push      = bus.req_valid & w_req_ready;
    assign w_entry     = '{we: bus.req_we, addr: bus.req_addr,
                           ds: bus.req_ds, wdata: bus.req_wdata};

    assign w_ack_seen  = (i_p2_ack != r_ack_exp);
    // The head leaves the FIFO exactly when its access completes.
    assign w_pop       = i_ram_ready & (r_state == ST_ISSUE) & w_ack_seen;

    sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Single-outstanding access sequencer. ack_exp always tracks the ack
    // line whenever no access is outstanding (idle, controller not ready,
    // reset), so stray toggles never complete a later access early.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ack_exp   <= i_p2_ack;
            r_p2_cs     <= 1'b0;
            r_p2_we     <= 1'b0;
            r_p2_addr   <= '0;
            r_p2_ds     <= '0;
            r_p2_din    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (!i_ram_ready) begin
                // An in-flight access is abandoned; its entry stays queued.
                r_ack_exp <= i_p2_ack;
                r_p2_cs   <= 1'b0;
                r_state   <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_ack_exp <= i_p2_ack;
                        if (!w_empty) begin
                            r_p2_cs   <= 1'b1;
                            r_p2_we   <= w_head.we;
                            r_p2_addr <= w_head.addr;
                            r_p2_ds   <= w_head.ds;
                            r_p2_din  <= w_head.wdata;
                            r_state   <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (w_ack_seen) begin
                            r_p2_cs     <= 1'b0;
                            r_ack_exp   <= i_p2_ack;
                            r_rsp_rdata <= i_p2_dout;
                            r_rsp_we    <= w_head.we;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_we    = r_rsp_we;
    assign bus.rsp_rdata = r_rsp_rdata;

    assign o_p2_cs   = r_p2_cs;
    assign o_p2_we   = r_p2_we;
    assign o_p2_addr = r_p2_addr;
    assign o_p2_ds   = r_p2_ds;
    assign o_p2_din  = r_p2_din;
    assign o_level   = w_level;
    assign o_busy    = (w_level != '0) | (r_state != ST_IDLE);

endmodule

// File: doc/sdram_p2_bridge.md
SDRAM_P2_BRIDGE -- requirements
Module: sdram_p2_bridge

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries (power of two, 2..16).
REQ-002 Ports: clk in 1, sole clock, same as SDRAM controller (32 MHz). All logic is on the rising edge.
REQ-003 Ports: reset_n in 1; reset is synchronous and active-low.
REQ-004 Ports: ram_ready in 1, controller initialised.
REQ-005 Ports, host request: req_valid in 1; req_ready out 1; req_we in 1; req_addr in 22 (word address); req_ds in 2 (byte mask for writes); req_wdata in 16.
REQ-006 Ports, host response: rsp_valid out 1 (one-cycle pulse); rsp_we out 1 (completed op was a write); rsp_rdata out 16.
REQ-007 Ports, controller port 2: p2_cs out 1; p2_we out 1; p2_addr out 22; p2_ds out 2; p2_din out 16; p2_dout in 16; p2_ack in 1 (toggles once per completed port-2 access).
REQ-008 Ports, status: level out log2(DEPTH)+1, FIFO occupancy; busy out 1, FIFO non-empty or access in flight.

Function
REQ-009 Request accept: a request is accepted on a clock edge where req_valid and req_ready are both 1. Each entry stores {we, addr, ds, wdata}.
REQ-010 req_ready = !full. A push while full is refused even if a pop occurs in the same cycle.
REQ-011 Push and pop in the same non-full cycle leave level unchanged. Pointers wrap modulo DEPTH.
REQ-012 FSM states: IDLE, ISSUE, DONE.
REQ-013 IDLE->ISSUE when FIFO non-empty and ram_ready=1. On that edge, p2_cs<=1 and p2_we/addr/ds/din are loaded from the FIFO head.
REQ-014 ISSUE: p2_cs and all p2_* outputs are held constant until p2_ack != ack_exp.
REQ-015 ISSUE->DONE on the edge where p2_ack != ack_exp. On that edge: p2_cs<=0, ack_exp<=p2_ack, rsp_rdata<=p2_dout, rsp_we<=head.we, FIFO head popped.
REQ-016 DONE: rsp_valid=1 for exactly this one cycle. DONE->IDLE unconditionally.
REQ-017 Latency: a request pushed into an empty FIFO in IDLE at edge t has p2_cs=1 after edge t+1. rsp_valid rises one cycle after the ack toggle edge.
REQ-018 rsp_rdata is undefined for writes, but is still loaded. rsp_rdata holds its value until the next completion.
REQ-019 Responses return in request order; at most one access is outstanding.
REQ-020 While ram_ready=0: no new issue; ack_exp<=p2_ack every cycle. An access already in ISSUE when ram_ready falls is abandoned (state->IDLE, entry kept, p2_cs<=0).
REQ-021 busy = (level!=0) | (state!=IDLE).

Reset
REQ-022 With reset_n=0 at an edge: state=IDLE, FIFO empty (level=0), req_ready=0 during reset, then 1.
REQ-023 Reset values: p2_cs=0, p2_we=0, p2_addr=0, p2_ds=0, p2_din=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, ack_exp<=p2_ack.
REQ-024 Reset mid-ISSUE drops the in-flight and queued requests; no response is generated.

Structure
REQ-025 Shared package holds the FSM state encoding and the port-2 address width (22).
REQ-026 One sub-module, sdram_req_fifo: synchronous FIFO with push, pop, full, empty and level.

Verification
REQ-027 Single read: read addr 0x12345 is queued. Controller model toggles p2_ack 5 cycles after p2_cs with p2_dout=0xBEEF -> rsp_valid pulse once, rsp_we=0, rsp_rdata=0xBEEF.
REQ-028 Write: we=1, addr 0x3FFFFF, ds=2'b01, wdata 0xA55A -> p2_* outputs show exactly these values while p2_cs=1. Completion gives rsp_we=1.
REQ-029 Full: 5 back-to-back pushes with DEPTH=4 and the ack withheld -> 5th push stalls with req_ready=0, level=4. The 5th push is accepted on the cycle after the first DONE.
REQ-030 Ordering: reads of 0x10, 0x20, 0x30 with distinct data -> responses arrive in the same order. Exactly one p2_ack toggle is consumed per response.
REQ-031 ram_ready=0 with 2 queued requests -> p2_cs stays 0. After ram_ready rises, both complete.
REQ-032 reset_n pulled low during ISSUE -> p2_cs=0 and level=0 next cycle. A stale p2_ack toggle arriving afterwards produces no rsp_valid.
